// File: rtl/huffman_pkg.sv
// ============================================================================
// Module : huffman_pkg
// Brief  : Shared constants, FSM state encoding and digit helper for freq_count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package huffman_pkg;

    localparam int NUM_SYM = 10;
    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b11
    } state_t;

    function automatic logic is_legal(input logic [DIGIT_W-1:0] d);
        return d < DIGIT_W'(NUM_SYM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/freq_cell.sv
// ============================================================================
// Module : freq_cell
// Brief  : One per-digit occurrence counter; FREQ_SAT_EN selects saturation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module freq_cell #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc) begin
`ifdef FREQ_SAT_EN
            if (r_count != {CNT_W{1'b1}}) begin
                r_count <= r_count + CNT_W'(1);
            end
`else
            r_count <= r_count + CNT_W'(1);
`endif
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/freq_count.sv
// ============================================================================
// Module : freq_count
// Brief  : Decimal digit histogram with session FSM; FREQ_SAT_EN saturates counts.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module freq_count
    import huffman_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               En,
    input  logic               Din_valid,
    input  logic [DIGIT_W-1:0] Din,
    input  logic               Din_last,
    output logic               Din_ready,
    output logic [CNT_W-1:0]   Count0,
    output logic [CNT_W-1:0]   Count1,
    output logic [CNT_W-1:0]   Count2,
    output logic [CNT_W-1:0]   Count3,
    output logic [CNT_W-1:0]   Count4,
    output logic [CNT_W-1:0]   Count5,
    output logic [CNT_W-1:0]   Count6,
    output logic [CNT_W-1:0]   Count7,
    output logic [CNT_W-1:0]   Count8,
    output logic [CNT_W-1:0]   Count9,
    output logic [CNT_W+3:0]   Total,
    output logic               Err,
    output logic               R_en
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start;
    logic               w_accept;
    logic               w_legal;
    logic [NUM_SYM-1:0] w_inc;
    logic [CNT_W-1:0]   w_count [NUM_SYM];
    logic [CNT_W+3:0]   r_total;
    logic               r_err;

    // Ready is gated by En so a digit offered on an abort cycle is never taken.
    assign w_start   = (r_state == IDLE) && En;
    assign Din_ready = (r_state == COUNT) && En;
    assign w_accept  = Din_valid && Din_ready;
    assign w_legal   = is_legal(Din);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (En) w_state_nxt = COUNT;
            COUNT: begin
                if (!En)                       w_state_nxt = IDLE;
                else if (w_accept && Din_last) w_state_nxt = DONE;
            end
            DONE:    if (!En) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || w_start) begin
            r_total <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            if (w_legal) r_total <= r_total + (CNT_W+4)'(1);
            else         r_err   <= 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < NUM_SYM; i++) begin : g_cell
            assign w_inc[i] = w_accept && w_legal && (Din == DIGIT_W'(i));

            freq_cell #(
                .CNT_W (CNT_W)
            ) u_cell (
                .clk   (Clk),
                .rst   (Rst),
                .clr   (w_start),
                .inc   (w_inc[i]),
                .count (w_count[i])
            );
        end
    endgenerate

    assign Count0 = w_count[0];
    assign Count1 = w_count[1];
    assign Count2 = w_count[2];
    assign Count3 = w_count[3];
    assign Count4 = w_count[4];
    assign Count5 = w_count[5];
    assign Count6 = w_count[6];
    assign Count7 = w_count[7];
    assign Count8 = w_count[8];
    assign Count9 = w_count[9];
    assign Total  = r_total;
    assign Err    = r_err;
    assign R_en   = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_freq_count.sv
// ============================================================================
// Module : tb_freq_count
// Brief  : Self-checking bench for freq_count (honours FREQ_SAT_EN if defined).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_freq_count;

    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int TMOD  = 1 << (CNT_W + 4);

    logic             Clk;
    logic             Rst;
    logic             En;
    logic             Din_valid;
    logic [3:0]       Din;
    logic             Din_last;
    logic             Din_ready;
    logic [CNT_W-1:0] cnt [10];
    logic [CNT_W+3:0] Total;
    logic             Err;
    logic             R_en;

    freq_count #(.CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .En        (En),
        .Din_valid (Din_valid),
        .Din       (Din),
        .Din_last  (Din_last),
        .Din_ready (Din_ready),
        .Count0    (cnt[0]),
        .Count1    (cnt[1]),
        .Count2    (cnt[2]),
        .Count3    (cnt[3]),
        .Count4    (cnt[4]),
        .Count5    (cnt[5]),
        .Count6    (cnt[6]),
        .Count7    (cnt[7]),
        .Count8    (cnt[8]),
        .Count9    (cnt[9]),
        .Total     (Total),
        .Err       (Err),
        .R_en      (R_en)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference: a histogram of the session plus a session phase (0 idle, 1 counting, 2 done).
    int m_cnt [10];
    int m_total;
    int m_err;
    int m_phase;

    typedef struct {
        int len;
        int d [8];
        int c [10];
        int total;
        int err;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 10; i++) m_cnt[i] = 0;
        m_total = 0;
        m_err   = 0;
    endtask

    task automatic model_edge();
        if (Rst) begin
            model_clear();
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (En) begin
                model_clear();
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!En) begin
                m_phase = 0;
            end else if (Din_valid) begin
                if (int'(Din) < 10) begin
`ifdef FREQ_SAT_EN
                    if (m_cnt[Din] < MAXC) m_cnt[Din] = m_cnt[Din] + 1;
`else
                    m_cnt[Din] = (m_cnt[Din] + 1) % (MAXC + 1);
`endif
                    m_total = (m_total + 1) % TMOD;
                end else begin
                    m_err = 1;
                end
                if (Din_last) m_phase = 2;
            end
        end else begin
            if (!En) m_phase = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(negedge Clk);
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s count%0d", tag, i), int'(cnt[i]), m_cnt[i]);
        chk({tag, " total"}, int'(Total), m_total);
        chk({tag, " err"}, int'(Err), m_err);
        chk({tag, " r_en"}, int'(R_en), (m_phase == 2) ? 1 : 0);
        chk({tag, " din_ready"}, int'(Din_ready), (m_phase == 1 && En) ? 1 : 0);
    endtask

    task automatic send(input int d, input bit last);
        Din_valid = 1'b1;
        Din       = 4'(d);
        Din_last  = last;
        tick();
        Din_valid = 1'b0;
        Din_last  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            tbl[i].d = '{0, 0, 0, 0, 0, 0, 0, 0};
            tbl[i].c = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        end
        tbl[0].len = 5; tbl[0].d = '{3, 3, 7, 0, 3, 0, 0, 0};
        tbl[0].c = '{1, 0, 0, 3, 0, 0, 0, 1, 0, 0}; tbl[0].total = 5; tbl[0].err = 0;
        tbl[1].len = 3; tbl[1].d = '{5, 12, 5, 0, 0, 0, 0, 0};
        tbl[1].c = '{0, 0, 0, 0, 0, 2, 0, 0, 0, 0}; tbl[1].total = 2; tbl[1].err = 1;
        tbl[2].len = 1; tbl[2].d = '{9, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].c = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1}; tbl[2].total = 1; tbl[2].err = 0;
        tbl[3].len = 8; tbl[3].d = '{15, 10, 1, 2, 4, 8, 6, 1};
        tbl[3].c = '{0, 2, 1, 0, 1, 0, 1, 0, 1, 0}; tbl[3].total = 6; tbl[3].err = 1;

        model_clear();
        m_phase   = 0;
        Rst       = 1'b1;
        En        = 1'b0;
        Din_valid = 1'b0;
        Din       = 4'd0;
        Din_last  = 1'b0;
        @(negedge Clk);
        tick();
        tick();
        Rst = 1'b0;
        chk("reset total", int'(Total), 0);
        chk("reset r_en", int'(R_en), 0);
        check_outputs("reset");

        // Table-driven sessions
        for (int k = 0; k < 4; k++) begin
            En = 1'b1;
            tick();
            for (int j = 0; j < tbl[k].len; j++) send(tbl[k].d[j], j == tbl[k].len - 1);
            chk($sformatf("tbl%0d r_en", k), int'(R_en), 1);
            for (int i = 0; i < 10; i++)
                chk($sformatf("tbl%0d count%0d", k, i), int'(cnt[i]), tbl[k].c[i]);
            chk($sformatf("tbl%0d total", k), int'(Total), tbl[k].total);
            chk($sformatf("tbl%0d err", k), int'(Err), tbl[k].err);
            tick();
            check_outputs($sformatf("tbl%0d hold", k));
            En = 1'b0;
            tick();
            check_outputs($sformatf("tbl%0d release", k));
        end

        // Long run of nines: overflow behaviour
        En = 1'b1;
        tick();
        for (int j = 0; j < 300; j++) send(9, 1'b0);
        send(9, 1'b1);
`ifdef FREQ_SAT_EN
        chk("ovf count9", int'(cnt[9]), 255);
`else
        chk("ovf count9", int'(cnt[9]), 45);
`endif
        chk("ovf total", int'(Total), 301);
        check_outputs("ovf");
        En = 1'b0;
        tick();

        // Abort after two digits; the digit on the abort cycle is dropped
        En = 1'b1;
        tick();
        send(4, 1'b0);
        send(6, 1'b0);
        En = 1'b0;
        send(2, 1'b1);
        chk("abort r_en", int'(R_en), 0);
        chk("abort count2", int'(cnt[2]), 0);
        chk("abort count4", int'(cnt[4]), 1);
        for (int j = 0; j < 3; j++) begin
            tick();
            check_outputs("abort idle");
        end
        En = 1'b1;
        tick();
        chk("restart count4", int'(cnt[4]), 0);
        check_outputs("restart");

        // Reset in DONE with Count1=4, En held high
        for (int j = 0; j < 4; j++) send(1, j == 3);
        chk("pre-rst count1", int'(cnt[1]), 4);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("rst count1", int'(cnt[1]), 0);
        chk("rst r_en", int'(R_en), 0);
        chk("rst din_ready", int'(Din_ready), 0);
        check_outputs("rst done");
        En = 1'b0;
        tick();

        // Digits offered in IDLE and DONE are ignored
        for (int j = 0; j < 3; j++) begin
            send(2, 1'b0);
            chk("idle count2", int'(cnt[2]), 0);
            chk("idle din_ready", int'(Din_ready), 0);
        end
        En = 1'b1;
        tick();
        send(7, 1'b1);
        for (int j = 0; j < 3; j++) begin
            send(2, 1'b1);
            chk("done count2", int'(cnt[2]), 0);
            chk("done din_ready", int'(Din_ready), 0);
            check_outputs("done ignore");
        end
        En = 1'b0;
        tick();

        // Randomised traffic against the reference
        for (int n = 0; n < 2000; n++) begin
            Rst       = ($urandom_range(0, 299) == 0);
            En        = ($urandom_range(0, 99) < 93);
            Din_valid = ($urandom_range(0, 99) < 70);
            Din       = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
            Din_last  = ($urandom_range(0, 99) < 4);
            tick();
            check_outputs("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/freq_count.md
FREQ_COUNT -- requirements
Module: freq_count

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of each per-digit frequency counter.
REQ-002 SHALL have port Clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port En, input, 1 bit: level enable; rising use starts a count session, low aborts or releases.
REQ-005 SHALL have port Din_valid, input, 1 bit: Din carries a digit this cycle.
REQ-006 SHALL have port Din, input, 4 bits: digit symbol; legal range 0-9.
REQ-007 SHALL have port Din_last, input, 1 bit: qualifies the final digit of the stream; meaningful only with Din_valid.
REQ-008 SHALL have port Din_ready, output, 1 bit: block accepts a digit this cycle.
REQ-009 SHALL have ports Count0..Count9, each output, CNT_W bits: occurrence count of digits 0..9; these feed the minimum-pair selector.
REQ-010 SHALL have port Total, output, CNT_W+4 bits: number of legal digits accepted this session.
REQ-011 SHALL have port Err, output, 1 bit: sticky flag; an illegal digit (10-15) was received this session.
REQ-012 SHALL have port R_en, output, 1 bit: counts final and stable; drives the selector's En.

Function
REQ-013 SHALL implement three states: IDLE, COUNT and DONE.
REQ-014 IDLE SHALL move to COUNT when En=1; on that edge Count0..9, Total and Err clear to 0.
REQ-015 Din_ready SHALL be 1 only in COUNT; a digit is accepted when Din_valid & Din_ready.
REQ-016 An accepted legal digit d SHALL increment Count<d> and Total by 1; the new values are visible the next cycle.
REQ-017 An accepted illegal digit SHALL set Err and SHALL leave all counts and Total unchanged.
REQ-018 An accepted digit with Din_last=1 SHALL be counted and SHALL move COUNT to DONE; R_en=1 on the following cycle with the final counts.
REQ-019 R_en SHALL be 1 exactly when state is DONE; the counts SHALL hold while in DONE.
REQ-020 DONE SHALL move to IDLE when En=0; the counts SHALL hold in IDLE until the next session starts.
REQ-021 En=0 in COUNT SHALL abort to IDLE with R_en=0; any digit offered that cycle is not accepted.
REQ-022 Din_valid outside COUNT SHALL be ignored.
REQ-023 Total SHALL wrap modulo 2^(CNT_W+4).
REQ-024 Count overflow behaviour SHALL be set by REQ-028.

Reset
REQ-025 Rst=1 SHALL force IDLE and set Count0..9, Total, Err, R_en and Din_ready to 0 on the next edge.
REQ-026 Rst SHALL have priority over En and Din_valid, including mid-session; the session is discarded.

Configuration
REQ-027 Macro FREQ_SAT_EN SHALL select the counter overflow behaviour.
REQ-028 With FREQ_SAT_EN defined, each Count SHALL saturate at 2^CNT_W-1. Without it, each Count SHALL wrap modulo 2^CNT_W. Total is unaffected in both cases.

Structure
REQ-029 Package huffman_pkg SHALL hold NUM_SYM=10, DIGIT_W=4 and the state encoding (IDLE=2'b00, COUNT=2'b01, DONE=2'b11).
REQ-030 Sub-module freq_cell SHALL be instantiated 10 times: one CNT_W counter with clr and inc inputs, honouring FREQ_SAT_EN.

Verification
REQ-031 Stream 3,3,7,0,3(last) after En=1 -> next cycle R_en=1, Count3=3, Count7=1, Count0=1, all other counts 0, Total=5, Err=0.
REQ-032 Stream 5,12,5(last) -> Count5=2, Total=2, Err=1; a digit value of 12 changes no count.
REQ-033 300 digits of 9 then last -> Count9=255 with FREQ_SAT_EN; Count9=45 without it (301 mod 256); Total=301.
REQ-034 En dropped after 2 digits -> IDLE next cycle, R_en never 1, Din_ready=0; a new En clears the counts.
REQ-035 Rst=1 in DONE with Count1=4 -> next cycle all outputs 0 and state IDLE.
REQ-036 Din_valid=1 with Din=2 while in IDLE or DONE -> no count change; Din_ready=0 throughout.
